// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage: FSM state encoding,
// default bus timeout and the MEM/WB bundle with its bubble value.
package mem_pkg;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic        reg_wr;
    logic        memto_reg;
    logic [4:0]  wr_reg;
    logic [31:0] alu_out;
    logic [31:0] mem_data;
  } wb_bundle_t;

  localparam wb_bundle_t WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures the write-back bundle when load_i is
// high, otherwise inserts a bubble. Asynchronous active-low reset.
module mem_wb_reg
  import mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       load_i,
  input  wb_bundle_t d_i,
  output wb_bundle_t q_o
);

  wb_bundle_t wb_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_q <= WB_BUBBLE;
    end else if (load_i) begin
      wb_q <= d_i;
    end else begin
      wb_q <= WB_BUBBLE;
    end
  end

  assign q_o = wb_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: drives the req/ack data-memory bus from EX/MEM, stalls the
// pipeline while an access is outstanding and feeds the MEM/WB register.
// Optional misaligned-access trap is enabled with `define MEM_ALIGN_CHECK_EN.
//
// Bus handshake: mem_req rises one edge after the access is seen in IDLE and
// mem_we/mem_addr/mem_wdata stay constant until the cycle in which mem_ack=1
// (one-cycle completion) or the timeout fires; mem_ack outside BUSY is ignored.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEM_ALUout,
  input  logic [31:0] MEM_rt_data,
  input  logic        MEM_MemWr,
  input  logic        MEM_MemtoReg,
  input  logic        MEM_RegWr,
  input  logic [4:0]  MEM_Write_register,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        WB_RegWr,
  output logic        WB_MemtoReg,
  output logic [4:0]  WB_Write_register,
  output logic [31:0] WB_ALUout,
  output logic [31:0] WB_MemData,
  output logic        err_timeout,
  output logic        err_misalign,
  output state_t      dbg_state
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic        mis_d;
  logic        acc;
  logic        misalign;
  logic        stall_c;
  logic        wb_load;
  wb_bundle_t  wb_d;
  wb_bundle_t  wb_q;

  assign acc = MEM_MemWr | MEM_MemtoReg;

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q;

  assign misalign = acc & (|MEM_ALUout[1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign err_misalign = mis_q;
`else
  logic unused_align_bits;

  assign misalign          = 1'b0;
  assign unused_align_bits = ^{MEM_ALUout[1:0], mis_d};
  assign err_misalign      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    mis_d   = 1'b0;
    stall_c = 1'b0;
    wb_load = 1'b0;
    wb_d    = '{reg_wr:    MEM_RegWr,
                memto_reg: MEM_MemtoReg,
                wr_reg:    MEM_Write_register,
                alu_out:   MEM_ALUout,
                mem_data:  32'h0};
    case (state_q)
      IDLE: begin
        if (!acc) begin
          wb_load = 1'b1;
        end else if (misalign) begin
          // Trapped access: instruction retires without a register write.
          wb_load     = 1'b1;
          wb_d.reg_wr = 1'b0;
          mis_d       = 1'b1;
        end else begin
          stall_c = 1'b1;
          req_d   = 1'b1;
          we_d    = MEM_MemWr;
          addr_d  = {MEM_ALUout[31:2], 2'b00};
          wdata_d = MEM_rt_data;
          cnt_d   = 8'h0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          // Ack wins over a coincident timeout.
          wb_load       = 1'b1;
          wb_d.mem_data = MEM_MemtoReg ? mem_rdata : 32'h0;
          req_d         = 1'b0;
          state_d       = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          wb_load     = 1'b1;
          wb_d.reg_wr = 1'b0;
          req_d       = 1'b0;
          tmo_d       = 1'b1;
          state_d     = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'h1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 8'h0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk_i   (clk),
    .rst_n_i (reset),
    .load_i  (wb_load),
    .d_i     (wb_d),
    .q_o     (wb_q)
  );

  // Gate with reset so stall drops at once even if EX/MEM still holds an access.
  assign stall             = reset & stall_c;
  assign mem_req           = req_q;
  assign mem_we            = we_q;
  assign mem_addr          = addr_q;
  assign mem_wdata         = wdata_q;
  assign err_timeout       = tmo_q;
  assign WB_RegWr          = wb_q.reg_wr;
  assign WB_MemtoReg       = wb_q.memto_reg;
  assign WB_Write_register = wb_q.wr_reg;
  assign WB_ALUout         = wb_q.alu_out;
  assign WB_MemData        = wb_q.mem_data;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT=4): ALU pass-through, loads,
// stores, timeout, back-to-back accesses, async reset and alignment handling.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] MEM_ALUout;
  logic [31:0] MEM_rt_data;
  logic        MEM_MemWr;
  logic        MEM_MemtoReg;
  logic        MEM_RegWr;
  logic [4:0]  MEM_Write_register;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        WB_RegWr;
  logic        WB_MemtoReg;
  logic [4:0]  WB_Write_register;
  logic [31:0] WB_ALUout;
  logic [31:0] WB_MemData;
  logic        err_timeout;
  logic        err_misalign;
  state_t      dbg_state;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .MEM_ALUout         (MEM_ALUout),
    .MEM_rt_data        (MEM_rt_data),
    .MEM_MemWr          (MEM_MemWr),
    .MEM_MemtoReg       (MEM_MemtoReg),
    .MEM_RegWr          (MEM_RegWr),
    .MEM_Write_register (MEM_Write_register),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_ack            (mem_ack),
    .mem_rdata          (mem_rdata),
    .stall              (stall),
    .WB_RegWr           (WB_RegWr),
    .WB_MemtoReg        (WB_MemtoReg),
    .WB_Write_register  (WB_Write_register),
    .WB_ALUout          (WB_ALUout),
    .WB_MemData         (WB_MemData),
    .err_timeout        (err_timeout),
    .err_misalign       (err_misalign),
    .dbg_state          (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Drive a new EX/MEM instruction (called at a falling edge).
  task automatic set_instr(input logic [31:0] addr, input logic [31:0] data,
                           input logic wr, input logic ld, input logic rw,
                           input logic [4:0] rd);
    MEM_ALUout         = addr;
    MEM_rt_data        = data;
    MEM_MemWr          = wr;
    MEM_MemtoReg       = ld;
    MEM_RegWr          = rw;
    MEM_Write_register = rd;
  endtask

  task automatic nop();
    set_instr(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  // Advance one clock; return just after the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    nop();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",    32'(mem_req), 32'h0);
    chk("rst_stall",  32'(stall), 32'h0);
    chk("rst_wbrw",   32'(WB_RegWr), 32'h0);
    chk("rst_tmo",    32'(err_timeout), 32'h0);
    chk("rst_state",  32'(dbg_state), 32'(IDLE));
    reset = 1'b1;

    // ALU instruction, with a stray ack in IDLE that must be ignored
    set_instr(32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    #1 chk("alu_stall", 32'(stall), 32'h0);
    tick();
    mem_ack = 1'b0;
    chk("alu_wb_alu", WB_ALUout, 32'h1234);
    chk("alu_wb_rd",  32'(WB_Write_register), 32'd5);
    chk("alu_wb_rw",  32'(WB_RegWr), 32'h1);
    chk("alu_wb_md",  WB_MemData, 32'h0);
    chk("alu_req",    32'(mem_req), 32'h0);

    // Load 0x100, ack two cycles after mem_req: three stall cycles
    set_instr(32'h100, 32'h0, 1'b0, 1'b1, 1'b1, 5'd7);
    #1 chk("ld_stall0", 32'(stall), 32'h1);
    chk("ld_req0", 32'(mem_req), 32'h0);
    tick();
    chk("ld_req1",   32'(mem_req), 32'h1);
    chk("ld_addr",   mem_addr, 32'h100);
    chk("ld_we",     32'(mem_we), 32'h0);
    chk("ld_state",  32'(dbg_state), 32'(BUSY));
    chk("ld_stall1", 32'(stall), 32'h1);
    chk("ld_bubble", 32'(WB_RegWr), 32'h0);
    tick();
    chk("ld_stall2", 32'(stall), 32'h1);
    chk("ld_req2",   32'(mem_req), 32'h1);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1 chk("ld_stall3", 32'(stall), 32'h0);
    tick();
    mem_ack = 1'b0;
    nop();
    chk("ld_wb_md",  WB_MemData, 32'hDEAD_BEEF);
    chk("ld_wb_m2r", 32'(WB_MemtoReg), 32'h1);
    chk("ld_wb_rw",  32'(WB_RegWr), 32'h1);
    chk("ld_wb_rd",  32'(WB_Write_register), 32'd7);
    chk("ld_req_off", 32'(mem_req), 32'h0);
    tick();

    // Store 0x204, immediate ack
    set_instr(32'h204, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 5'd0);
    #1 chk("st_stall0", 32'(stall), 32'h1);
    tick();
    chk("st_req",   32'(mem_req), 32'h1);
    chk("st_we",    32'(mem_we), 32'h1);
    chk("st_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("st_addr",  mem_addr, 32'h204);
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    #1 chk("st_stall1", 32'(stall), 32'h0);
    tick();
    mem_ack = 1'b0;
    nop();
    chk("st_wb_md",  WB_MemData, 32'h0);
    chk("st_wb_alu", WB_ALUout, 32'h204);
    chk("st_req_off", 32'(mem_req), 32'h0);
    tick();

    // Load with no ack: TIMEOUT=4 busy cycles, then abort
    set_instr(32'h300, 32'h0, 1'b0, 1'b1, 1'b1, 5'd9);
    #1 chk("to_stall0", 32'(stall), 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("to_req%0d", k), 32'(mem_req), 32'h1);
      chk($sformatf("to_tmo%0d", k), 32'(err_timeout), 32'h0);
      chk($sformatf("to_stall%0d", k + 1), 32'(stall), (k < 3) ? 32'h1 : 32'h0);
    end
    tick();
    nop();
    chk("to_req_off", 32'(mem_req), 32'h0);
    chk("to_pulse",   32'(err_timeout), 32'h1);
    chk("to_wb_rw",   32'(WB_RegWr), 32'h0);
    chk("to_wb_md",   WB_MemData, 32'h0);
    chk("to_wb_alu",  WB_ALUout, 32'h300);
    chk("to_state",   32'(dbg_state), 32'(IDLE));
    tick();
    chk("to_pulse_end", 32'(err_timeout), 32'h0);

    // Ack coincident with the timeout cycle: ack wins
    set_instr(32'h400, 32'h0, 1'b0, 1'b1, 1'b1, 5'd3);
    repeat (4) tick();
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    #1 chk("race_stall", 32'(stall), 32'h0);
    tick();
    mem_ack = 1'b0;
    nop();
    chk("race_tmo",   32'(err_timeout), 32'h0);
    chk("race_wb_md", WB_MemData, 32'h0BAD_F00D);
    chk("race_wb_rw", 32'(WB_RegWr), 32'h1);
    tick();
    chk("race_tmo2",  32'(err_timeout), 32'h0);

    // Back-to-back loads 0x10 and 0x14, each acked in the first BUSY cycle
    set_instr(32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd1);
    tick();
    chk("bb_req_a",  32'(mem_req), 32'h1);
    chk("bb_addr_a", mem_addr, 32'h10);
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0;
    set_instr(32'h14, 32'h0, 1'b0, 1'b1, 1'b1, 5'd2);
    chk("bb_wb_md_a", WB_MemData, 32'h1111_1111);
    chk("bb_wb_rd_a", 32'(WB_Write_register), 32'd1);
    chk("bb_noreiss", 32'(mem_req), 32'h0);
    #1 chk("bb_stall_b", 32'(stall), 32'h1);
    tick();
    chk("bb_req_b",  32'(mem_req), 32'h1);
    chk("bb_addr_b", mem_addr, 32'h14);
    mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    mem_ack = 1'b0;
    nop();
    chk("bb_wb_md_b", WB_MemData, 32'h2222_2222);
    chk("bb_wb_rd_b", 32'(WB_Write_register), 32'd2);
    tick();
    chk("bb_idle_req", 32'(mem_req), 32'h0);

    // Asynchronous reset in the middle of BUSY
    set_instr(32'h500, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4);
    tick();
    chk("rb_req", 32'(mem_req), 32'h1);
    #2 reset = 1'b0;
    #1 chk("rb_req_off", 32'(mem_req), 32'h0);
    chk("rb_stall", 32'(stall), 32'h0);
    chk("rb_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    nop();
    reset = 1'b1;
    tick();
    chk("rb_after", 32'(mem_req), 32'h0);

    // Misaligned load at 0x102
    set_instr(32'h102, 32'h0, 1'b0, 1'b1, 1'b1, 5'd6);
`ifdef MEM_ALIGN_CHECK_EN
    #1 chk("mis_stall", 32'(stall), 32'h0);
    tick();
    nop();
    chk("mis_req",   32'(mem_req), 32'h0);
    chk("mis_pulse", 32'(err_misalign), 32'h1);
    chk("mis_wb_rw", 32'(WB_RegWr), 32'h0);
    chk("mis_wb_md", WB_MemData, 32'h0);
    tick();
    chk("mis_end",   32'(err_misalign), 32'h0);
`else
    #1 chk("mis_stall", 32'(stall), 32'h1);
    tick();
    chk("mis_req",  32'(mem_req), 32'h1);
    chk("mis_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'h6666_6666;
    tick();
    mem_ack = 1'b0;
    nop();
    chk("mis_flag",  32'(err_misalign), 32'h0);
    chk("mis_wb_md", WB_MemData, 32'h6666_6666);
    chk("mis_wb_rw", 32'(WB_RegWr), 32'h1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
